// File: rtl/uart_tx_sequencer.sv
// UART TX frame sequencer: round-robin arbitration between two byte requesters,
// baud timing and mux select generation. Define UART_TX_TWO_STOP_BITS_EN for two stop bits.
module uart_tx_sequencer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic [3:0] sel,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       done,
   output logic       grant_id
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_TWO_STOP_BITS_EN
   localparam logic [2:0] STOP_LAST = 3'd1;
`else
   localparam logic [2:0] STOP_LAST = 3'd0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [3:0]       sel_q, sel_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             grant_id_q, grant_id_d;
   logic             baud_tc_s;

   // Next-state, arbitration and registered-output computation
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      data_out_d = data_out_q;
      grant_id_d = grant_id_q;
      busy_d     = busy_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      done_d     = 1'b0;
      sel_d      = 4'b0000;
      baud_tc_s  = (baud_q == BAUD_LAST);

      case (state_q)
         ST_IDLE: begin
            baud_d    = '0;
            bit_idx_d = 3'd0;
            // On a tie the requester that did not go last wins
            if (req0 && (!req1 || grant_id_q)) begin
               data_out_d = data0;
               grant_id_d = 1'b0;
               ack0_d     = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_START;
            end else if (req1) begin
               data_out_d = data1;
               grant_id_d = 1'b1;
               ack1_d     = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_START;
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_START: begin
            if (baud_tc_s) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_tc_s) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
                  state_d   = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            // bit_idx counts stop bits here
            if (baud_tc_s) begin
               baud_d = '0;
               if (bit_idx_q == STOP_LAST) begin
                  bit_idx_d = 3'd0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            baud_d    = '0;
            bit_idx_d = 3'd0;
            busy_d    = 1'b0;
         end
      endcase

      case (state_d)
         ST_START: sel_d = 4'b0001;
         ST_DATA:  sel_d = 4'd2 + {1'b0, bit_idx_d};
         ST_IDLE:  sel_d = 4'b0000;
         ST_STOP:  sel_d = 4'b0000;
         default:  sel_d = 4'b0000;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= 3'd0;
         sel_q      <= 4'b0000;
         data_out_q <= 8'h00;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         grant_id_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         sel_q      <= sel_d;
         data_out_q <= data_out_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign sel      = sel_q;
   assign data_out = data_out_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign grant_id = grant_id_q;

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Controller that drives the UART TX bit multiplexer's 4-bit select (0000 idle/stop=1, 0001 start=0, 0010..1001 DATA[0..7]) and its 8-bit DATA input.
- Generates bit timing from a baud counter and walks the frame START → D0..D7 → STOP.
- Arbitrates the single transmitter between two byte requesters with round-robin priority.
- Sits between the system's byte producers and the mux; the mux output is the TX line.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range ≥ 2. Counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 has a byte; held until ack0
- data0  input  8  requester 0 byte; stable while req0=1
- req1  input  1  requester 1 has a byte; held until ack1
- data1  input  8  requester 1 byte; stable while req1=1
- ack0  output  1  one-cycle pulse: data0 accepted
- ack1  output  1  one-cycle pulse: data1 accepted
- sel  output  4  select to the TX mux, registered
- data_out  output  8  latched frame byte to the mux DATA input, registered
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse: frame completed
- grant_id  output  1  source of the current or last frame (0/1)

Behaviour:
- Reset (rst=1 at an edge): state IDLE; sel=0000; data_out=8'h00; ack0=ack1=0; busy=0; done=0; grant_id=1 (so requester 0 wins the first tie); baud counter and bit index = 0. Reset mid-frame aborts immediately: sel=0000 after that edge, no done pulse, and the pending byte is dropped.
- States:
  - IDLE: sel=0000.
  - START: sel=0001.
  - DATA: sel=0010+bit_idx, bit_idx 0..7.
  - STOP: sel=0000.
- IDLE arbitration is sampled at each edge:
  - One request high: that requester is granted.
  - Both high: the requester ≠ grant_id wins.
  - Grant edge: data_out←data_x, grant_id←x, ack_x=1 for exactly one cycle, busy=1, state→START, baud counter=0.
- Each bit is held for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1. At terminal count it wraps to 0 and the state/bit advances.
- DATA: bit_idx increments at each terminal count. At bit_idx=7 with terminal count, state→STOP.
- STOP terminal count: state→IDLE, busy=0, done=1 for one cycle.
- busy is high for exactly 10*CLKS_PER_BIT cycles per frame. IDLE can grant on the first IDLE cycle, so back-to-back frames have a gap of exactly 1 cycle with sel=0000 (line high).
- Requests are ignored while busy. A req dropped before its ack is not served. ack is never asserted for a requester whose req is low.
- data_out is stable for the whole frame, and changes only on a grant edge or on reset.
- sel never takes values 1010..1111.

Optional Feature:
- Macro: UART_TX_TWO_STOP_BITS_EN.
- Defined: STOP lasts 2*CLKS_PER_BIT cycles (sel=0000 throughout). busy is high for 11*CLKS_PER_BIT cycles. done pulses at the end of the second stop bit.
- Undefined: one stop bit, as above.

Test Plan (CLKS_PER_BIT=4):
- Single frame: after reset, req0=1, data0=8'hA5 → ack0 one cycle; then sel sequence 0001 ×4, 0010..1001 each ×4, 0000 ×4; decoded TX = 0,1,0,1,0,0,1,0,1,1; busy high 40 cycles; done one cycle after; grant_id=0.
- Tie and round-robin: req0=req1=1 continuously, data0=8'h11, data1=8'h22 → frames alternate 11,22,11,22 starting with 11; one idle cycle between frames; each ack pulses once per frame.
- Ignore while busy: req1 pulses high for 3 cycles mid-frame and drops before IDLE → no ack1, no second frame, sel stays 0000 after done.
- Reset mid-frame: rst=1 during DATA bit 3 → the next cycle shows sel=0000, busy=0, data_out=00, no done; a subsequent req1 with data 8'h3C transmits correctly.
- Data stability: change data0 after ack0 mid-frame → transmitted bits still match the originally latched byte.
- Two stop bits (macro defined): single 8'hFF frame → STOP sel=0000 for 8 cycles; busy high 44 cycles; done once.
